// File: rtl/mem_pkg.sv
// Shared types and field indices for the MEM stage.
// Holds the access FSM state enum and the m_MEM / wb_MEM bit positions.
package mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_e;

   // m_MEM fields
   localparam int BRANCH     = 2;
   localparam int MEM_READ   = 1;
   localparam int MEM_WRITE  = 0;

   // wb_MEM fields
   localparam int REG_WRITE  = 1;
   localparam int MEM_TO_REG = 0;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for an outstanding data-memory access (MEM_TIMEOUT_EN only).
// Ports: clk, rst_n, start (entering BUSY), busy, ack -> abort_raw.
module mem_timeout_ctr
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic busy,
   input  logic ack,
   output logic abort_raw
);

   localparam int W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (busy && !ack && cnt != LIMIT) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign abort_raw = busy && (cnt == LIMIT);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access, stall, MEM/WB register.
// Ports: EX/MEM inputs, dmem_* port, stall, pcsrc, *_WB outputs,
// mem_err (only when MEM_TIMEOUT_EN is defined). TIMEOUT_CYC sizes the abort.
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] res,
   input  logic [31:0] write_data_ex,
   input  logic [4:0]  write_register,
   input  logic        zero,
   input  logic [2:0]  m_MEM,
   input  logic [1:0]  wb_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        pcsrc,
   output logic [1:0]  wb_WB,
   output logic [31:0] read_data,
   output logic [31:0] alu_res_WB,
`ifdef MEM_TIMEOUT_EN
   output logic [4:0]  write_register_WB,
   output logic        mem_err
`else
   output logic [4:0]  write_register_WB
`endif
);

   mem_state_e state, state_nxt;

   logic        access;
   logic        req_c, we_c;
   logic [31:0] addr_c, wdata_c;
   logic        cap_we;
   logic [31:0] cap_addr, cap_wdata;
   logic        go_busy;
   logic        abort;
   logic        done_rd;

   assign access = m_MEM[MEM_READ] | m_MEM[MEM_WRITE];
   assign pcsrc  = m_MEM[BRANCH] & zero;

   assign go_busy = (state == IDLE) && access && !dmem_ack;

`ifdef MEM_TIMEOUT_EN
   logic abort_raw;

   mem_timeout_ctr #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (go_busy),
      .busy     (state == BUSY),
      .ack      (dmem_ack),
      .abort_raw(abort_raw)
   );

   // a late ack beats the timeout
   assign abort = abort_raw & ~dmem_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_err <= 1'b0;
      end else if (abort) begin
         mem_err <= 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_c     = 1'b0;
      we_c      = 1'b0;
      addr_c    = '0;
      wdata_c   = '0;
      unique case (state)
         IDLE: begin
            if (access) begin
               req_c   = 1'b1;
               // both bits set counts as a write
               we_c    = m_MEM[MEM_WRITE];
               addr_c  = {res[31:2], 2'b00};
               wdata_c = write_data_ex;
               if (!dmem_ack) state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (dmem_ack || abort) state_nxt = IDLE;
            if (!abort) begin
               req_c   = 1'b1;
               we_c    = cap_we;
               addr_c  = cap_addr;
               wdata_c = cap_wdata;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // reset kills the request at once, even with an access on the inputs
   assign dmem_req   = rst_n & req_c;
   assign dmem_we    = rst_n & we_c;
   assign dmem_addr  = rst_n ? addr_c  : '0;
   assign dmem_wdata = rst_n ? wdata_c : '0;

   assign stall   = dmem_req & ~dmem_ack & ~abort;
   assign done_rd = dmem_req & dmem_ack & ~dmem_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else if (go_busy) begin
         cap_we    <= m_MEM[MEM_WRITE];
         cap_addr  <= {res[31:2], 2'b00};
         cap_wdata <= write_data_ex;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_WB             <= '0;
         read_data         <= '0;
         alu_res_WB        <= '0;
         write_register_WB <= '0;
      end else if (stall) begin
         // bubble: WB must not write the register twice
         wb_WB <= 2'b00;
      end else begin
         wb_WB             <= abort ? 2'b00 : wb_MEM;
         read_data         <= done_rd ? dmem_rdata : 32'h0;
         alu_res_WB        <= res;
         write_register_WB <= write_register;
      end
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, sitting between the EX/MEM register (driven by the EX stage) and the write-back stage. It consumes the EX stage's ALU result, store data, destination register and control bundles, performs load/store transfers on a req/ack data-memory port, stalls the pipeline while a transfer is outstanding, and registers the MEM/WB pipeline state. It also resolves the branch decision from the EX stage's zero flag.

## Interface
- `TIMEOUT_CYC`, default 255: maximum wait cycles in BUSY before an access is aborted (used only with MEM_TIMEOUT_EN).
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `res`  in  32: ALU result from EX; it is the memory address for loads and stores.
- `write_data_ex`  in  32: store data from EX.
- `write_register`  in  5: destination register from EX.
- `zero`  in  1: ALU zero flag from EX.
- `m_MEM`  in  3: memory control; [2]=branch, [1]=mem_read, [0]=mem_write.
- `wb_MEM`  in  2: write-back control; [1]=reg_write, [0]=mem_to_reg.
- `dmem_req`  out  1: memory request.
- `dmem_we`  out  1: 1 = write, 0 = read; valid while `dmem_req` is high.
- `dmem_addr`  out  32: word address, equal to `{res[31:2],2'b00}`.
- `dmem_wdata`  out  32: store data.
- `dmem_ack`  in  1: transfer completes on any edge where `dmem_req` and `dmem_ack` are both high.
- `dmem_rdata`  in  32: read data, valid when `dmem_ack` is high.
- `stall`  out  1: hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `pcsrc`  out  1: take branch, equal to `m_MEM[2] & zero` (combinational).
- `wb_WB`  out  2: registered write-back control.
- `read_data`  out  32: registered load data.
- `alu_res_WB`  out  32: registered ALU result.
- `write_register_WB`  out  5: registered destination register.
- `mem_err`  out  1: sticky timeout flag (present only with MEM_TIMEOUT_EN).

## Operation
- An access is present when `m_MEM[1] | m_MEM[0]`. If both bits are set, the access is treated as a write and the registered `read_data` is 0.
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - With an access present, `dmem_req` is driven high combinationally from the current inputs.
  - If `dmem_ack` is also high, the transfer completes that cycle and the FSM stays in IDLE.
  - Otherwise the FSM goes to BUSY and latches addr, wdata and we into capture registers.
- BUSY:
  - `dmem_req` is high and the address, data and direction come from the capture registers.
  - On `dmem_ack` the FSM returns to IDLE.
- `stall` = `dmem_req & ~dmem_ack & ~abort`.
- MEM/WB register:
  - Loads on every edge where `stall` is 0.
  - `read_data` takes `dmem_rdata` on completion of a read, otherwise 0.
  - On stall edges `wb_WB` is loaded with 2'b00, which inserts a bubble so no register is written twice.
  - The `read_data`, `alu_res_WB` and `write_register_WB` fields hold their values on stall edges.
- The EX/MEM inputs are stable during a stall because the upstream registers hold.

## Timing
- Reset:
  - FSM goes to IDLE.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `stall` = 0.
  - `wb_WB`, `read_data`, `alu_res_WB`, `write_register_WB` = 0.
  - `mem_err` = 0.
- Zero-wait memory (ack in the same cycle as req): latency 1 cycle and no stall.
- N-cycle memory: `stall` is high for N cycles and the result reaches MEM/WB on the ack edge.
- Reset asserted mid-transfer: `dmem_req` drops immediately (asynchronous) and the transfer is abandoned.
- A non-access instruction (ALU or branch) passes through in 1 cycle. `pcsrc` is never concurrent with a stall.
- A new request is accepted in the cycle immediately after a completion (back-to-back accesses).

## Configuration
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to BUSY and increments on each BUSY cycle without ack.
  - When the counter reaches `TIMEOUT_CYC`, `abort` is asserted for one cycle: `dmem_req` drops, `stall` is 0, MEM/WB loads with `wb_WB`=00 (the instruction is squashed), the FSM goes to IDLE and `mem_err` sets sticky until reset.
  - An ack arriving in the abort cycle wins, and the transfer completes normally.
- Undefined:
  - The counter, `abort` and the `mem_err` port are absent.
  - BUSY waits indefinitely for ack.

## Structure
- Package `mem_pkg` holds:
  - the state enum {IDLE, BUSY};
  - the field-index constants for `m_MEM` and `wb_MEM` (BRANCH, MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG).
- Sub-module `mem_timeout_ctr` (counter plus abort compare) is instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Load, zero-wait: `res`=0x104, `m_MEM`=010, `wb_MEM`=11, ack in the same cycle, rdata=0xDEADBEEF -> `dmem_addr`=0x104, no stall; next edge `read_data`=0xDEADBEEF, `wb_WB`=11.
- Store, 3-cycle ack: `res`=0x20, `write_data_ex`=0x55 -> `dmem_we`=1 and `dmem_wdata`=0x55 for 3 cycles, `stall` high for 2 cycles, `wb_WB`=00 during the stall.
- Misaligned address `res`=0x107 -> `dmem_addr`=0x104.
- Branch: `m_MEM`=100, `zero`=1 -> `pcsrc`=1, no `dmem_req`; with `zero`=0 -> `pcsrc`=0.
- `rst_n` low during BUSY -> `dmem_req` 0 immediately; after release the FSM is in IDLE and all outputs are 0.
- MEM_TIMEOUT_EN with `TIMEOUT_CYC`=4 and no ack -> abort after 4 BUSY cycles, `mem_err`=1, `stall`=0, `wb_WB`=00.
